// File: rtl/sr_shift_ctrl.sv
// rtl/sr_shift_ctrl.sv - serial shift-register transfer controller
// Generates SCK, shifts D out on SDO, captures SDI and presents the result on Q.
module sr_shift_ctrl #(
   parameter int Width = 16,
   parameter int Left  = 0,
   parameter int Half  = 2
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             START,
   input  logic [4:0]       NBITS,
   input  logic [Width-1:0] D,
   input  logic             SDI,
   output logic             SCK,
   output logic             SDO,
   output logic [Width-1:0] Q,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOW    = 2'd1;
   localparam logic [1:0] ST_HIGH   = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [4:0] WIDTH_N  = 5'(Width);
   localparam logic [7:0] HALF_END = 8'(Half - 1);

   logic [1:0]       state_q, state_d;
   logic [Width-1:0] shift_q, shift_d;
   logic [Width-1:0] shifted;
   logic [4:0]       cnt_q, cnt_d;
   logic [4:0]       nbits_eff;
   logic [7:0]       phase_q, phase_d;
   logic             cap_q, cap_d;
   logic             sck_q, sck_d;
   logic             sdo_q, sdo_d;
   logic             sdo_next;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [Width-1:0] q_q, q_d;

   // Direction only changes which end leaves on SDO and which end takes SDI.
   generate
      if (Left != 0) begin : g_msb_first
         assign shifted  = {shift_q[Width-2:0], cap_q};
         assign sdo_next = shift_d[Width-1];
      end else begin : g_lsb_first
         assign shifted  = {cap_q, shift_q[Width-1:1]};
         assign sdo_next = shift_d[0];
      end
   endgenerate

   assign nbits_eff = (NBITS == 5'd0 || NBITS > WIDTH_N) ? WIDTH_N : NBITS;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      cap_d   = cap_q;
      q_d     = q_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               shift_d = D;
               cnt_d   = nbits_eff;
               phase_d = 8'd0;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            if (phase_q == HALF_END) begin
               phase_d = 8'd0;
               cap_d   = SDI;
               state_d = ST_HIGH;
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end
         ST_HIGH: begin
            if (phase_q == HALF_END) begin
               phase_d = 8'd0;
               shift_d = shifted;
               cnt_d   = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  q_d     = shifted;
                  state_d = ST_FINISH;
               end else begin
                  state_d = ST_LOW;
               end
            end else begin
               phase_d = phase_q + 8'd1;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they line up with it.
      sck_d  = (state_d == ST_HIGH);
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FINISH);
      sdo_d  = (state_d == ST_LOW) ? sdo_next : sdo_q;
   end

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= 5'd0;
         phase_q <= 8'd0;
         cap_q   <= 1'b0;
         sck_q   <= 1'b0;
         sdo_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         q_q     <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         cap_q   <= cap_d;
         sck_q   <= sck_d;
         sdo_q   <= sdo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         q_q     <= q_d;
      end
   end

   assign SCK  = sck_q;
   assign SDO  = sdo_q;
   assign Q    = q_q;
   assign BUSY = busy_q;
   assign DONE = done_q;

endmodule

// File: tb/tb_sr_shift_ctrl.sv
// tb/tb_sr_shift_ctrl.sv - self-checking bench for sr_shift_ctrl
// Three instances: LSB-first loopback, MSB-first driven SDI, and Half=255 loopback.
module tb_sr_shift_ctrl;

   logic        C = 1'b0;
   logic        CLR;
   logic        start0, start1, start2, sdi1;
   logic [4:0]  nb0, nb1, nb2;
   logic [15:0] d0, d1, d2;
   logic        sck0, sdo0, busy0, done0;
   logic        sck1, sdo1, busy1, done1;
   logic        sck2, sdo2, busy2, done2;
   logic [15:0] q0, q1, q2;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q0, exp_q1, exp_q2;

   logic        obs_sck  [0:1100];
   logic        obs_sdo  [0:1100];
   logic        obs_busy [0:1100];
   logic        obs_done [0:1100];
   logic [15:0] obs_q    [0:1100];
   int          obs_len;

   always #5 C = ~C;

   sr_shift_ctrl #(.Width(16), .Left(0), .Half(2)) u0 (
      .C(C), .CLR(CLR), .START(start0), .NBITS(nb0), .D(d0), .SDI(sdo0),
      .SCK(sck0), .SDO(sdo0), .Q(q0), .BUSY(busy0), .DONE(done0));

   sr_shift_ctrl #(.Width(16), .Left(1), .Half(1)) u1 (
      .C(C), .CLR(CLR), .START(start1), .NBITS(nb1), .D(d1), .SDI(sdi1),
      .SCK(sck1), .SDO(sdo1), .Q(q1), .BUSY(busy1), .DONE(done1));

   sr_shift_ctrl #(.Width(16), .Left(0), .Half(255)) u2 (
      .C(C), .CLR(CLR), .START(start2), .NBITS(nb2), .D(d2), .SDI(sdo2),
      .SCK(sck2), .SDO(sdo2), .Q(q2), .BUSY(busy2), .DONE(done2));

   function automatic int eff_n(input logic [4:0] nb);
      return (nb == 5'd0 || nb > 5'd16) ? 16 : int'(nb);
   endfunction

   // s[i] is the i-th bit returned on SDI; loopback LSB-first returns D itself.
   function automatic logic [15:0] model_q(input int left, input logic [15:0] d,
                                           input int n, input logic [15:0] s);
      logic [31:0] dd, ss, mask, r;
      dd   = {16'h0, d};
      ss   = {16'h0, s};
      mask = (32'd1 << n) - 32'd1;
      if (left == 0) begin
         r = (dd >> n) | ((ss & mask) << (16 - n));
      end else begin
         r = dd << n;
         for (int i = 0; i < n; i++) r = r | (32'(s[i]) << (n - 1 - i));
      end
      return r[15:0];
   endfunction

   function automatic int wave_errs(input int left, input int h, input int n,
                                    input logic [15:0] d, input logic [15:0] q_old,
                                    input logic [15:0] q_new);
      int   errs, per, p;
      logic e_sck, e_sdo;
      errs = 0;
      per  = 2 * h * n;
      if (obs_len != per + 2) return 1000 + obs_len;
      for (int k = 1; k <= per + 2; k++) begin
         p     = (k <= per) ? (k - 1) / (2 * h) : n - 1;
         e_sdo = (left != 0) ? d[15 - p] : d[p];
         e_sck = (k <= per) && (((k - 1) / h) % 2 == 1);
         if (obs_sck[k]  !== e_sck)                          errs++;
         if (obs_sdo[k]  !== e_sdo)                          errs++;
         if (obs_busy[k] !== (k <= per + 1))                 errs++;
         if (obs_done[k] !== (k == per + 1))                 errs++;
         if (obs_q[k]    !== ((k <= per) ? q_old : q_new))   errs++;
      end
      return errs;
   endfunction

   function automatic int count_rises();
      int r;
      r = 0;
      for (int k = 1; k <= obs_len; k++)
         if (obs_sck[k] && (k == 1 || !obs_sck[k-1])) r++;
      return r;
   endfunction

   task automatic capture(input int inst, input logic [15:0] d, input logic [4:0] nb,
                          input logic [15:0] pat, input int limit);
      int   falls, done_at;
      logic prev;
      obs_len = 0;
      falls   = 0;
      done_at = -1;
      prev    = 1'b0;
      @(negedge C);
      case (inst)
         0:       begin d0 = d; nb0 = nb; start0 = 1'b1; end
         1:       begin d1 = d; nb1 = nb; sdi1 = pat[0]; start1 = 1'b1; end
         default: begin d2 = d; nb2 = nb; start2 = 1'b1; end
      endcase
      @(posedge C);
      #1;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      for (int k = 1; k <= limit; k++) begin
         @(negedge C);
         case (inst)
            0: begin obs_sck[k] = sck0; obs_sdo[k] = sdo0; obs_busy[k] = busy0;
                     obs_done[k] = done0; obs_q[k] = q0; end
            1: begin obs_sck[k] = sck1; obs_sdo[k] = sdo1; obs_busy[k] = busy1;
                     obs_done[k] = done1; obs_q[k] = q1; end
            default: begin obs_sck[k] = sck2; obs_sdo[k] = sdo2; obs_busy[k] = busy2;
                           obs_done[k] = done2; obs_q[k] = q2; end
         endcase
         obs_len = k;
         if (inst == 1) begin
            if (prev && !sck1) begin
               falls++;
               if (falls < 16) sdi1 = pat[falls];
            end
            prev = sck1;
         end
         if (done_at < 0 && obs_done[k]) done_at = k;
         if (done_at > 0 && k == done_at + 1) break;
      end
   endtask

   task automatic test_reset();
      CLR = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; sdi1 = 1'b0;
      nb0 = 5'd0; nb1 = 5'd0; nb2 = 5'd0;
      d0 = 16'h0; d1 = 16'h0; d2 = 16'h0;
      exp_q0 = 16'h0; exp_q1 = 16'h0; exp_q2 = 16'h0;
      repeat (3) @(negedge C);
      checks++;
      if ({sck0, sdo0, busy0, done0} !== 4'b0) begin
         errors++; $display("FAIL reset_ctl0 got %b exp 0000", {sck0, sdo0, busy0, done0});
      end
      checks++;
      if (q0 !== 16'h0) begin errors++; $display("FAIL reset_q0 got %h exp 0000", q0); end
      checks++;
      if ({sck1, sdo1, busy1, done1, q1, sck2, sdo2, busy2, done2, q2} !== 40'h0) begin
         errors++; $display("FAIL reset_u1u2 got %h exp 0",
                            {sck1, sdo1, busy1, done1, q1, sck2, sdo2, busy2, done2, q2});
      end
      CLR = 1'b0;
      repeat (2) @(negedge C);
      checks++;
      if (busy0 !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 0", busy0); end
   endtask

   task automatic test_loopback_a5();
      int e, done_at;
      logic [15:0] qn;
      qn = model_q(0, 16'h00A5, 8, 16'h00A5);
      capture(0, 16'h00A5, 5'd8, 16'h0, 200);
      e = wave_errs(0, 2, 8, 16'h00A5, exp_q0, qn);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL a5_wave got %0d bad cycles exp 0", e); end
      checks++;
      if (count_rises() !== 8) begin
         errors++; $display("FAIL a5_pulses got %0d exp 8", count_rises());
      end
      done_at = 0;
      for (int k = 1; k <= obs_len; k++) if (obs_done[k] && done_at == 0) done_at = k;
      checks++;
      if (done_at !== 33) begin errors++; $display("FAIL a5_done_cycle got %0d exp 33", done_at); end
      checks++;
      if (q0 !== 16'hA500) begin errors++; $display("FAIL a5_q got %h exp a500", q0); end
      exp_q0 = 16'hA500;
   endtask

   task automatic test_msb_first();
      int e, nbusy;
      capture(1, 16'h8001, 5'd0, 16'hFFFF, 200);
      e = wave_errs(1, 1, 16, 16'h8001, exp_q1, 16'hFFFF);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL msb_wave got %0d bad cycles exp 0", e); end
      checks++;
      if (count_rises() !== 16) begin
         errors++; $display("FAIL msb_pulses got %0d exp 16", count_rises());
      end
      nbusy = 0;
      for (int k = 1; k <= obs_len; k++) if (obs_busy[k]) nbusy++;
      checks++;
      if (nbusy !== 33) begin errors++; $display("FAIL msb_busy_len got %0d exp 33", nbusy); end
      checks++;
      if (q1 !== 16'hFFFF) begin errors++; $display("FAIL msb_q got %h exp ffff", q1); end
      exp_q1 = 16'hFFFF;
   endtask

   task automatic test_nbits_over();
      logic [15:0] d;
      d = 16'h3C5A;
      capture(0, d, 5'd20, 16'h0, 200);
      checks++;
      if (count_rises() !== 16) begin
         errors++; $display("FAIL nbits20_pulses got %0d exp 16", count_rises());
      end
      checks++;
      if (q0 !== d) begin errors++; $display("FAIL nbits20_q got %h exp %h", q0, d); end
      exp_q0 = d;
   endtask

   task automatic test_random_lsb();
      logic [15:0] d, qn;
      logic [4:0]  nb;
      int n, e;
      for (int it = 0; it < 6; it++) begin
         d  = 16'($urandom);
         nb = 5'($urandom_range(0, 31));
         n  = eff_n(nb);
         qn = model_q(0, d, n, d);
         capture(0, d, nb, 16'h0, 4 * n + 10);
         e = wave_errs(0, 2, n, d, exp_q0, qn);
         checks++;
         if (e !== 0) begin errors++; $display("FAIL rnd_lsb_wave n=%0d got %0d bad cycles exp 0", n, e); end
         checks++;
         if (q0 !== qn) begin errors++; $display("FAIL rnd_lsb_q n=%0d got %h exp %h", n, q0, qn); end
         exp_q0 = qn;
      end
   endtask

   task automatic test_random_msb();
      logic [15:0] d, pat, qn;
      logic [4:0]  nb;
      int n, e;
      for (int it = 0; it < 5; it++) begin
         d   = 16'($urandom);
         pat = 16'($urandom);
         nb  = 5'($urandom_range(1, 16));
         n   = eff_n(nb);
         qn  = model_q(1, d, n, pat);
         capture(1, d, nb, pat, 2 * n + 10);
         e = wave_errs(1, 1, n, d, exp_q1, qn);
         checks++;
         if (e !== 0) begin errors++; $display("FAIL rnd_msb_wave n=%0d got %0d bad cycles exp 0", n, e); end
         checks++;
         if (q1 !== qn) begin errors++; $display("FAIL rnd_msb_q n=%0d got %h exp %h", n, q1, qn); end
         exp_q1 = qn;
      end
   endtask

   task automatic test_back_to_back();
      int per_len, bad, ndone, extra;
      logic [15:0] d;
      d       = 16'($urandom);
      per_len = 2 * 2 * 3 + 2;
      bad     = 0;
      ndone   = 0;
      extra   = 0;
      @(negedge C);
      d0 = d; nb0 = 5'd3; start0 = 1'b1;
      for (int k = 1; k <= 3 * per_len; k++) begin
         @(negedge C);
         if (busy0 !== (((k - 1) % per_len) < per_len - 1)) bad++;
         if (done0 !== (((k - 1) % per_len) == per_len - 2)) bad++;
         if (done0) ndone++;
      end
      start0 = 1'b0;
      repeat (4) begin
         @(negedge C);
         if (busy0 || done0) extra++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL b2b_timing got %0d bad samples exp 0", bad); end
      checks++;
      if (ndone !== 3) begin errors++; $display("FAIL b2b_done_count got %0d exp 3", ndone); end
      checks++;
      if (extra !== 0) begin errors++; $display("FAIL b2b_no_extra got %0d exp 0", extra); end
      exp_q0 = model_q(0, d, 3, d);
      checks++;
      if (q0 !== exp_q0) begin errors++; $display("FAIL b2b_q got %h exp %h", q0, exp_q0); end
   endtask

   task automatic test_clr_abort();
      int rises, dseen, e;
      logic prev;
      rises = 0;
      prev  = 1'b0;
      dseen = 0;
      @(negedge C);
      d0 = 16'($urandom); nb0 = 5'd16; start0 = 1'b1;
      @(posedge C);
      #1 start0 = 1'b0;
      for (int k = 0; k < 200 && rises < 3; k++) begin
         @(negedge C);
         if (sck0 && !prev) rises++;
         prev = sck0;
      end
      checks++;
      if (rises !== 3) begin errors++; $display("FAIL clr_wait_rises got %0d exp 3", rises); end
      #2 CLR = 1'b1;
      #1;
      checks++;
      if ({sck0, sdo0, busy0, done0} !== 4'b0) begin
         errors++; $display("FAIL clr_async_ctl got %b exp 0000", {sck0, sdo0, busy0, done0});
      end
      checks++;
      if (q0 !== 16'h0) begin errors++; $display("FAIL clr_async_q got %h exp 0000", q0); end
      @(negedge C);
      CLR = 1'b0;
      exp_q0 = 16'h0; exp_q1 = 16'h0; exp_q2 = 16'h0;
      repeat (6) begin
         @(negedge C);
         if (done0 || busy0) dseen++;
      end
      checks++;
      if (dseen !== 0) begin errors++; $display("FAIL clr_no_done got %0d exp 0", dseen); end
      capture(0, 16'h1234, 5'd16, 16'h0, 200);
      e = wave_errs(0, 2, 16, 16'h1234, 16'h0, 16'h1234);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL clr_restart_wave got %0d bad cycles exp 0", e); end
      checks++;
      if (q0 !== 16'h1234) begin errors++; $display("FAIL clr_restart_q got %h exp 1234", q0); end
      exp_q0 = 16'h1234;
   endtask

   task automatic test_half_255();
      logic [15:0] d, qn;
      int e, first_rise;
      d  = 16'($urandom);
      qn = model_q(0, d, 2, d);
      capture(2, d, 5'd2, 16'h0, 1100);
      e = wave_errs(0, 255, 2, d, exp_q2, qn);
      checks++;
      if (e !== 0) begin errors++; $display("FAIL h255_wave got %0d bad cycles exp 0", e); end
      first_rise = 0;
      for (int k = 1; k <= obs_len; k++) if (obs_sck[k] && first_rise == 0) first_rise = k;
      checks++;
      if (first_rise !== 256) begin errors++; $display("FAIL h255_low_len got %0d exp 256", first_rise); end
      checks++;
      if (q2 !== qn) begin errors++; $display("FAIL h255_q got %h exp %h", q2, qn); end
      exp_q2 = qn;
   endtask

   initial begin
      test_reset();
      test_loopback_a5();
      test_msb_first();
      test_nbits_over();
      test_random_lsb();
      test_random_msb();
      test_back_to_back();
      test_clr_abort();
      test_half_255();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
